// File: rtl/traffic_pkg.sv
// Shared encodings for the intersection controller: FSM state codes,
// approach indices and the one-hot lamp helper.
package traffic_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_GREEN  = 2'd1;
  localparam logic [1:0] ST_YELLOW = 2'd2;
  localparam logic [1:0] ST_ALLRED = 2'd3;

  localparam logic [1:0] APP_N = 2'd0;
  localparam logic [1:0] APP_E = 2'd1;
  localparam logic [1:0] APP_S = 2'd2;
  localparam logic [1:0] APP_W = 2'd3;

  function automatic logic [3:0] onehot4(input logic [1:0] idx);
    logic [3:0] v;
    v = 4'b0000;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational 4-way rotate-priority picker: returns the first set bit of
// pend_nx, searching upward from phase+1 and wrapping modulo 4.
module rr_pick4
  import traffic_pkg::*;
(
  input  logic [3:0] pend_nx,
  input  logic [1:0] phase,
  output logic       valid,
  output logic [1:0] pick
);

  logic [1:0] start_s;
  logic [7:0] dbl_s;
  logic [3:0] rot_s;
  logic [1:0] off_s;

  // Rotate so that bit 0 of rot_s is the approach after the one just served.
  assign start_s = phase + 2'd1;
  assign dbl_s   = {pend_nx, pend_nx};
  assign rot_s   = dbl_s[{1'b0, start_s} +: 4];

  // Priority encode the rotated request vector.
  always_comb begin
    valid = 1'b1;
    off_s = 2'd0;
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: begin
        valid = 1'b0;
        off_s = 2'd0;
      end
    endcase
  end

  assign pick = start_s + off_s;

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Four-approach intersection controller: latches detector requests, serves
// them round-robin and times green / yellow / all-red intervals.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int GREEN_CYC  = 8,
  parameter int YELLOW_CYC = 3,
  parameter int ALLRED_CYC = 2,
  parameter int CNT_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] red,
  output logic [3:0] yellow,
  output logic [3:0] green,
  output logic [1:0] phase,
  output logic [1:0] state
);

  localparam logic [CNT_W-1:0] G_LOAD   = CNT_W'(GREEN_CYC - 1);
  localparam logic [CNT_W-1:0] Y_LOAD   = CNT_W'(YELLOW_CYC - 1);
  localparam logic [CNT_W-1:0] A_LOAD   = CNT_W'(ALLRED_CYC - 1);
  localparam logic [CNT_W-1:0] T_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] T_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_r, state_nx_s;
  logic [1:0]       phase_r, phase_nx_s;
  logic [CNT_W-1:0] timer_r, timer_nx_s;
  logic [3:0]       pend_r, pend_nx_s, pend_keep_s, mask_s;
  logic             enter_green_s;
  logic             timer_zero_s;
  logic             pick_valid_s;
  logic [1:0]       pick_s;
  logic [3:0]       red_r, yellow_r, green_r;
  logic [3:0]       red_nx_s, yellow_nx_s, green_nx_s;

  // The approach holding green cannot re-request itself.
  assign mask_s       = (state_r == ST_GREEN) ? onehot4(phase_r) : 4'b0000;
  assign pend_nx_s    = (pend_r | req) & ~mask_s;
  assign timer_zero_s = (timer_r == T_ZERO);
  assign pend_keep_s  = enter_green_s ? (pend_nx_s & ~onehot4(pick_s)) : pend_nx_s;

  rr_pick4 u_pick (
    .pend_nx (pend_nx_s),
    .phase   (phase_r),
    .valid   (pick_valid_s),
    .pick    (pick_s)
  );

  // State, phase, timer and pending-request registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      phase_r <= APP_W;
      timer_r <= T_ZERO;
      pend_r  <= 4'b0000;
    end else begin
      state_r <= state_nx_s;
      phase_r <= phase_nx_s;
      timer_r <= timer_nx_s;
      pend_r  <= pend_keep_s;
    end
  end

  // Next-state, next-phase and timer reload logic.
  always_comb begin
    state_nx_s    = state_r;
    phase_nx_s    = phase_r;
    timer_nx_s    = timer_r;
    enter_green_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (pick_valid_s) begin
          state_nx_s    = ST_GREEN;
          phase_nx_s    = pick_s;
          timer_nx_s    = G_LOAD;
          enter_green_s = 1'b1;
        end else begin
          timer_nx_s = T_ZERO;
        end
      end
      ST_GREEN: begin
        if (!timer_zero_s) begin
          timer_nx_s = timer_r - T_ONE;
        end else if (|pend_nx_s) begin
          state_nx_s = ST_YELLOW;
          timer_nx_s = Y_LOAD;
        end else begin
          timer_nx_s = T_ZERO;
        end
      end
      ST_YELLOW: begin
        if (timer_zero_s) begin
          state_nx_s = ST_ALLRED;
          timer_nx_s = A_LOAD;
        end else begin
          timer_nx_s = timer_r - T_ONE;
        end
      end
      ST_ALLRED: begin
        if (!timer_zero_s) begin
          timer_nx_s = timer_r - T_ONE;
        end else if (pick_valid_s) begin
          state_nx_s    = ST_GREEN;
          phase_nx_s    = pick_s;
          timer_nx_s    = G_LOAD;
          enter_green_s = 1'b1;
        end else begin
          state_nx_s = ST_IDLE;
          timer_nx_s = T_ZERO;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        timer_nx_s = T_ZERO;
      end
    endcase
  end

  // Lamp decode from next state so lamps switch on the same edge as state.
  always_comb begin
    green_nx_s  = 4'b0000;
    yellow_nx_s = 4'b0000;
    case (state_nx_s)
      ST_GREEN:  green_nx_s  = onehot4(phase_nx_s);
      ST_YELLOW: yellow_nx_s = onehot4(phase_nx_s);
      default: begin
        green_nx_s  = 4'b0000;
        yellow_nx_s = 4'b0000;
      end
    endcase
    red_nx_s = ~(green_nx_s | yellow_nx_s);
  end

  // Registered lamp drivers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_r    <= 4'hF;
      yellow_r <= 4'h0;
      green_r  <= 4'h0;
    end else begin
      red_r    <= red_nx_s;
      yellow_r <= yellow_nx_s;
      green_r  <= green_nx_s;
    end
  end

  assign red    = red_r;
  assign yellow = yellow_r;
  assign green  = green_r;
  assign phase  = phase_r;
  assign state  = state_r;

endmodule
